// File: rtl/flappy_pkg.sv
// Shared scene codes, keycodes, default gap bounds and the LFSR step function
// for the flappy game engine.
package flappy_pkg;

    typedef enum logic [1:0] {
        SCENE_SPLASH   = 2'd0,
        SCENE_PLAYING  = 2'd1,
        SCENE_GAMEOVER = 2'd2
    } scene_t;

    localparam logic [7:0] KEY_SPACE = 8'd32;
    localparam logic [7:0] KEY_X     = 8'd120;
    localparam logic [7:0] KEY_R     = 8'd114;

    // Default bound table: slots beyond the third reuse the slot-0 bounds.
    function automatic int unsigned default_max(input int unsigned k);
        case (k)
            1:       return 25;
            2:       return 35;
            default: return 30;
        endcase
    endfunction

    function automatic int unsigned default_min(input int unsigned k);
        case (k)
            1:       return 15;
            2:       return 25;
            default: return 20;
        endcase
    endfunction

    // x^16 + x^14 + x^13 + x^11, left-shifting Fibonacci form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/flappy_engine_lfsr16.sv
// Free-running 16-bit LFSR used as the gap respawn randomness source.
module lfsr16
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/flappy_engine.sv
// Flappy Bird game-state engine: scene FSM, tick-based bird physics,
// scrolling pipe gaps with LFSR respawn, collision detection and score.
module flappy_engine
    import flappy_pkg::*;
#(
    parameter int unsigned NUM_GAPS  = 3,
    parameter int unsigned COORD_W   = 8,
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned FLAP_VEL  = 3,
    parameter int unsigned MAX_FALL  = 4,
    parameter int unsigned MAX_ALT   = 40,
    parameter int unsigned INIT_ALT  = 20,
    parameter int unsigned INIT_X    = 20,
    parameter int unsigned SPACING   = 20,
    parameter int unsigned BIRD_X    = 2,
    parameter int unsigned PIPE_W    = 5,
    parameter int unsigned GAP_H     = 10,
    parameter int unsigned FLAP_HOLD = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [7:0]                      inp,
    output logic [1:0]                      scene,
    output logic [COORD_W:0]                bird,
    output logic [3*COORD_W*NUM_GAPS-1:0]   gaps,
    output logic [15:0]                     score
);

    localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW   = (FLAP_HOLD > 0) ? $clog2(FLAP_HOLD + 1) : 1;
    localparam int unsigned SW   = COORD_W + 2;
    localparam int unsigned SPAN = MAX_ALT - GAP_H - 10;

    typedef logic [COORD_W-1:0]        coord_t;
    typedef logic [COORD_W:0]          ext_t;
    typedef logic signed [SW-1:0]      wide_t;

    localparam wide_t FALL_LIM = -wide_t'(MAX_FALL);

    scene_t                      state;
    scene_t                      state_next;
    logic   [TW-1:0]             tick_cnt;
    logic                        playing;
    logic                        tick;
    logic                        flap;
    logic                        restart;
    coord_t                      alt;
    coord_t                      alt_next;
    logic signed [COORD_W-1:0]   vel;
    logic signed [COORD_W-1:0]   vel_next;
    wide_t                       alt_sum;
    wide_t                       vel_grav;
    logic   [HW-1:0]             hold_cnt;
    logic   [HW-1:0]             hold_next;
    logic   [16:0]               score_sum;
    logic   [15:0]               score_next;
    logic                        crash_q;
    logic                        crash_next;
    logic   [15:0]               lfsr_q;
    logic   [15:0]               lfsr_chain [NUM_GAPS];
    logic   [NUM_GAPS-1:0]       wrap;
    logic   [NUM_GAPS-1:0]       hit;

    assign playing = (state == SCENE_PLAYING);
    assign tick    = playing && (tick_cnt == TW'(TICK_DIV - 1));
    assign flap    = playing && (inp == KEY_SPACE);
    assign restart = (state == SCENE_GAMEOVER) && (inp == KEY_R);

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .step  (1'b1),
        .q     (lfsr_q)
    );

    // ---------------- scene FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCENE_SPLASH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SCENE_SPLASH:   if (inp != '0) state_next = SCENE_PLAYING;
            SCENE_PLAYING:  if (inp == KEY_X || crash_q) state_next = SCENE_GAMEOVER;
            SCENE_GAMEOVER: if (inp == KEY_R) state_next = SCENE_SPLASH;
            default:        state_next = SCENE_SPLASH;
        endcase
    end

    always_comb begin
        scene = state;
        bird  = {alt, hold_cnt != '0};
    end

    // ---------------- tick divider ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (!playing || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // ---------------- bird physics ----------------
    always_comb begin
        alt_sum  = $signed({2'b00, alt}) + $signed({{2{vel[COORD_W-1]}}, vel});
        vel_grav = $signed({{2{vel[COORD_W-1]}}, vel}) - wide_t'(GRAVITY);
        alt_next = alt;
        vel_next = vel;
        if (tick) begin
            if (alt_sum[SW-1]) begin
                alt_next = '0;
            end else if (alt_sum > wide_t'(MAX_ALT)) begin
                alt_next = coord_t'(MAX_ALT);
            end else begin
                alt_next = alt_sum[COORD_W-1:0];
            end
            vel_next = (vel_grav < FALL_LIM) ? FALL_LIM[COORD_W-1:0] : vel_grav[COORD_W-1:0];
        end
        // A flap overrides gravity; altitude above still used the old velocity.
        if (flap) begin
            vel_next = COORD_W'(FLAP_VEL);
        end
    end

    always_comb begin
        hold_next = hold_cnt;
        if (flap) begin
            hold_next = HW'(FLAP_HOLD);
        end else if (hold_cnt != '0) begin
            hold_next = hold_cnt - HW'(1);
        end
    end

    always_comb begin
        score_sum = {1'b0, score};
        for (int unsigned k = 0; k < NUM_GAPS; k++) begin
            score_sum = score_sum + 17'(wrap[k]);
        end
        score_next = score_sum[16] ? '1 : score_sum[15:0];
    end

    assign crash_next = tick && ((alt_next == '0) || (|hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alt      <= coord_t'(INIT_ALT);
            vel      <= '0;
            hold_cnt <= '0;
            score    <= '0;
            crash_q  <= 1'b0;
        end else if (restart) begin
            alt      <= coord_t'(INIT_ALT);
            vel      <= '0;
            hold_cnt <= '0;
            score    <= '0;
            crash_q  <= 1'b0;
        end else if (playing) begin
            alt      <= alt_next;
            vel      <= vel_next;
            hold_cnt <= hold_next;
            score    <= score_next;
            crash_q  <= crash_next;
        end
    end

    // ---------------- pipe gaps ----------------
    assign lfsr_chain[0] = lfsr_q;

    for (genvar k = 0; k < NUM_GAPS; k++) begin : g_gap
        localparam coord_t POS0 = coord_t'(INIT_X + k * SPACING);
        localparam coord_t MAX0 = coord_t'(default_max(k));
        localparam coord_t MIN0 = coord_t'(default_min(k));

        coord_t pos;
        coord_t bmax;
        coord_t bmin;
        coord_t pos_n;
        coord_t bmax_n;
        coord_t bmin_n;

        assign wrap[k] = tick && (pos == '0);

        always_comb begin
            pos_n  = pos;
            bmax_n = bmax;
            bmin_n = bmin;
            if (tick) begin
                if (pos == '0) begin
                    pos_n  = coord_t'(NUM_GAPS * SPACING - 1);
                    bmin_n = coord_t'(5 + (lfsr_chain[k] % SPAN));
                    bmax_n = bmin_n + coord_t'(GAP_H);
                end else begin
                    pos_n = pos - coord_t'(1);
                end
            end
        end

        // Each wrapping slot consumes one LFSR step so same-tick respawns differ.
        if (k + 1 < NUM_GAPS) begin : g_step
            assign lfsr_chain[k+1] = wrap[k] ? lfsr_next(lfsr_chain[k]) : lfsr_chain[k];
        end

        assign hit[k] = (pos_n <= coord_t'(BIRD_X))
                     && (ext_t'(BIRD_X) < ({1'b0, pos_n} + ext_t'(PIPE_W)))
                     && ((alt_next >= bmax_n) || (alt_next <= bmin_n));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pos  <= POS0;
                bmax <= MAX0;
                bmin <= MIN0;
            end else if (restart) begin
                pos  <= POS0;
                bmax <= MAX0;
                bmin <= MIN0;
            end else if (playing) begin
                pos  <= pos_n;
                bmax <= bmax_n;
                bmin <= bmin_n;
            end
        end

        assign gaps[(NUM_GAPS-k)*3*COORD_W-1 -: 3*COORD_W] = {pos, bmax, bmin};
    end

endmodule

// File: tb/tb_flappy_engine.sv
// Bench for flappy_engine: three parameter variants checked every cycle against
// an integer-level game model, plus literal expectations at key moments.
module tb_flappy_engine;

    localparam int NI = 3;
    localparam int NG = 3;
    localparam logic [71:0] INIT_GAPS = 72'h141E14_28190F_3C2319;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        chk_en;
    logic [7:0]  inp_w   [NI];
    logic [1:0]  scene_w [NI];
    logic [8:0]  bird_w  [NI];
    logic [71:0] gaps_w  [NI];
    logic [15:0] score_w [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    flappy_engine u0 (
        .clk(clk), .rst_n(rst_n), .inp(inp_w[0]),
        .scene(scene_w[0]), .bird(bird_w[0]), .gaps(gaps_w[0]), .score(score_w[0])
    );

    flappy_engine #(.GRAVITY(0), .INIT_ALT(25)) u1 (
        .clk(clk), .rst_n(rst_n), .inp(inp_w[1]),
        .scene(scene_w[1]), .bird(bird_w[1]), .gaps(gaps_w[1]), .score(score_w[1])
    );

    flappy_engine #(.GRAVITY(0), .INIT_ALT(20)) u2 (
        .clk(clk), .rst_n(rst_n), .inp(inp_w[2]),
        .scene(scene_w[2]), .bird(bird_w[2]), .gaps(gaps_w[2]), .score(score_w[2])
    );

    // ---------------- game model ----------------
    int cfg_grav [NI] = '{1, 0, 0};
    int cfg_alt0 [NI] = '{20, 25, 20};
    int dflt_max [NG] = '{30, 25, 35};
    int dflt_min [NG] = '{20, 15, 25};
    int exp_fall [8]  = '{20, 19, 17, 14, 10, 6, 2, 0};
    int exp_flap [5]  = '{23, 25, 26, 26, 25};

    int          m_scene [NI];
    int          m_alt   [NI];
    int          m_vel   [NI];
    int          m_hold  [NI];
    int          m_score [NI];
    int          m_tcnt  [NI];
    bit          m_pend  [NI];
    int          m_pos   [NI][NG];
    int          m_max   [NI][NG];
    int          m_min   [NI][NG];
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_init(input int i);
        m_scene[i] = 0;
        m_alt[i]   = cfg_alt0[i];
        m_vel[i]   = 0;
        m_hold[i]  = 0;
        m_score[i] = 0;
        m_tcnt[i]  = 0;
        m_pend[i]  = 1'b0;
        for (int k = 0; k < NG; k++) begin
            m_pos[i][k] = 20 + 20 * k;
            m_max[i][k] = dflt_max[k];
            m_min[i][k] = dflt_min[k];
        end
    endtask

    task automatic model_step();
        logic [15:0] r;
        int key;
        int nxt;
        bit tick;
        bit flap;
        for (int i = 0; i < NI; i++) begin
            key = int'(inp_w[i]);
            nxt = m_scene[i];
            if (m_scene[i] == 0 && key != 0) nxt = 1;
            if (m_scene[i] == 1 && (key == 120 || m_pend[i])) nxt = 2;
            if (m_scene[i] == 2 && key == 114) nxt = 0;
            if (m_scene[i] == 2 && key == 114) begin
                model_init(i);
            end else if (m_scene[i] == 1) begin
                tick = (m_tcnt[i] == 3);
                flap = (key == 32);
                m_tcnt[i] = tick ? 0 : m_tcnt[i] + 1;
                m_pend[i] = 1'b0;
                if (tick) begin
                    m_alt[i] = m_alt[i] + m_vel[i];
                    if (m_alt[i] < 0)  m_alt[i] = 0;
                    if (m_alt[i] > 40) m_alt[i] = 40;
                    r = m_lfsr;
                    for (int k = 0; k < NG; k++) begin
                        if (m_pos[i][k] == 0) begin
                            m_pos[i][k] = 59;
                            m_min[i][k] = 5 + (int'(r) % 20);
                            m_max[i][k] = m_min[i][k] + 10;
                            if (m_score[i] < 65535) m_score[i]++;
                            r = lfsr_step(r);
                        end else begin
                            m_pos[i][k]--;
                        end
                    end
                    if (m_alt[i] == 0) m_pend[i] = 1'b1;
                    for (int k = 0; k < NG; k++) begin
                        if (m_pos[i][k] <= 2 && 2 < m_pos[i][k] + 5 &&
                            (m_alt[i] >= m_max[i][k] || m_alt[i] <= m_min[i][k]))
                            m_pend[i] = 1'b1;
                    end
                end
                if (flap) begin
                    m_vel[i] = 3;
                end else if (tick) begin
                    m_vel[i] = m_vel[i] - cfg_grav[i];
                    if (m_vel[i] < -4) m_vel[i] = -4;
                end
                if (flap) m_hold[i] = 5;
                else if (m_hold[i] > 0) m_hold[i]--;
            end
            m_scene[i] = nxt;
        end
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    function automatic logic [71:0] model_gaps(input int i);
        logic [71:0] g;
        g = '0;
        for (int k = 0; k < NG; k++) begin
            g[(NG-k)*24-1 -: 24] = {8'(m_pos[i][k]), 8'(m_max[i][k]), 8'(m_min[i][k])};
        end
        return g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) model_init(i);
            m_lfsr = 16'hACE1;
        end else begin
            model_step();
        end
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("u%0d.scene", i), scene_w[i], 72'(m_scene[i]));
                check($sformatf("u%0d.bird", i), bird_w[i], {63'd0, 8'(m_alt[i]), m_hold[i] > 0});
                check($sformatf("u%0d.gaps", i), gaps_w[i], model_gaps(i));
                check($sformatf("u%0d.score", i), score_w[i], 72'(m_score[i]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int flap_cycles;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < NI; i++) inp_w[i] = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("reset.scene", scene_w[0], 0);
        check("reset.bird", bird_w[0], 9'h028);
        check("reset.score", score_w[0], 0);
        check("reset.gaps", gaps_w[0], INIT_GAPS);

        for (int i = 0; i < NI; i++) inp_w[i] = 8'd65;
        @(negedge clk);
        for (int i = 0; i < NI; i++) inp_w[i] = '0;
        check("start.scene", scene_w[0], 1);
        check("start.gaps", gaps_w[0], INIT_GAPS);
        check("start.bird", bird_w[0], 9'h028);

        repeat (4) @(negedge clk);
        for (int t = 1; t <= 38; t++) begin
            if (t <= 8) check($sformatf("fall.alt_tick%0d", t), bird_w[0][8:1], 72'(exp_fall[t-1]));
            if (t == 8) check("fall.scene_at_tick", scene_w[0], 1);
            if (t == 18) begin
                check("u2.gap0_pos", gaps_w[2][71:64], 2);
                check("u2.scene_at_tick", scene_w[2], 1);
            end
            if (t == 20) check("u1.score_before_wrap", score_w[1], 0);
            if (t == 21) begin
                check("u1.score_after_wrap", score_w[1], 1);
                check("u1.gap0_wrap_pos", gaps_w[1][71:64], 59);
            end
            if (t == 38) begin
                check("u1.gap1_pos", gaps_w[1][47:40], 2);
                check("u1.gap1_max", gaps_w[1][39:32], 25);
                check("u1.scene_at_tick", scene_w[1], 1);
            end
            @(negedge clk);
            if (t == 8)  check("fall.gameover", scene_w[0], 2);
            if (t == 18) check("u2.gameover", scene_w[2], 2);
            if (t == 38) check("u1.gameover", scene_w[1], 2);
            if (t < 38) repeat (3) @(negedge clk);
        end

        inp_w[0] = 8'd114;
        inp_w[1] = 8'd114;
        @(negedge clk);
        inp_w[0] = '0;
        inp_w[1] = '0;
        check("restart.scene", scene_w[0], 0);
        check("restart.gaps", gaps_w[0], INIT_GAPS);
        check("restart.bird", bird_w[0], 9'h028);
        check("restart.u1_score", score_w[1], 0);
        check("restart.u1_bird", bird_w[1], 9'h032);
        check("restart.u1_gaps", gaps_w[1], INIT_GAPS);

        inp_w[0] = 8'd65;
        @(negedge clk);
        inp_w[0] = 8'd32;
        flap_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            inp_w[0] = '0;
            if (bird_w[0][0]) flap_cycles++;
            if (i % 4 == 3) check($sformatf("flap.alt_tick%0d", i / 4 + 1), bird_w[0][8:1], 72'(exp_flap[i/4]));
        end
        check("flap.hold_cycles", 72'(flap_cycles), 5);

        inp_w[0] = 8'd120;
        @(negedge clk);
        inp_w[0] = '0;
        check("quit.scene", scene_w[0], 2);
        check("quit.alt", bird_w[0][8:1], 25);
        repeat (3) @(negedge clk);
        check("frozen.alt", bird_w[0][8:1], 25);
        check("frozen.scene", scene_w[0], 2);

        inp_w[0] = 8'd114;
        @(negedge clk);
        inp_w[0] = 8'd65;
        @(negedge clk);
        inp_w[0] = '0;
        check("replay.scene", scene_w[0], 1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async.scene", scene_w[0], 0);
        check("async.bird", bird_w[0], 9'h028);
        check("async.gaps", gaps_w[0], INIT_GAPS);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
